peripheral_mult: RTL and testbench



---
 rtl/peripheral_mult.sv | 123 ++++++++++++
 tb/tb_peripheral_mult.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/peripheral_mult.sv
// peripheral_mult: memory-mapped 16x16 unsigned shift-add multiplier.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   d_in   - 16-bit write data bus
//   cs     - chip select, active-high
//   addr   - 2-bit register address
//   rd     - read strobe, active-high
//   wr     - write strobe, active-high
//   d_out  - 16-bit read data bus (combinational read mux)
//
// Write map: 0 = A, 1 = B, 2 = control (bit 0 starts a multiply), 3 = none.
// Read map:  0 = product[15:0], 1 = product[31:16], 2 = {busy, done}, 3 = 0.
module peripheral_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [31:0] product;
    logic [3:0]  cnt;
    logic        done;
    logic        busy;
    logic        wr_en;
    logic        start;

    assign wr_en = cs & wr;
    // Level-sensitive start; ignored while BUSY so a held wr fires only once.
    assign start = wr_en && (addr == 2'd2) && d_in[0] && (state != BUSY);

    // One partial-product step of the shift-add engine.
    always_comb begin
        acc_next = acc;
        if (op_b[cnt]) begin
            acc_next = acc + ({16'h0000, op_a} << cnt);
        end
    end

    // Operand registers: always writable, the engine works on private copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (wr_en) begin
            if (addr == 2'd0) a_reg <= d_in;
            if (addr == 2'd1) b_reg <= d_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a_reg;
                        op_b  <= b_reg;
                        acc   <= '0;
                        cnt   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        d_out = '0;
        if (cs && rd) begin
            case (addr)
                2'd0:    d_out = product[15:0];
                2'd1:    d_out = product[31:16];
                2'd2:    d_out = {14'b0, busy, done};
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_mult.sv
module tb_peripheral_mult;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    logic        chk;
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          tests;
    int          fails;

    peripheral_mult dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever the bench presents a read cycle, pop and compare
    // away from the rising edge.
    always @(negedge clk) begin
        if (chk) begin
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL scoreboard_underflow: read seen with no expected value");
            end else begin
                logic [15:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (d_out !== e) begin
                    fails = fails + 1;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", n, d_out, e);
                end
            end
        end
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d,
                             input logic c, input int cycles);
        cs = c; wr = 1'b1; addr = a; d_in = d;
        idle(cycles);
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic c,
                            input logic [15:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        cs = c; rd = 1'b1; addr = a; chk = 1'b1;
        idle(1);
        cs = 1'b0; rd = 1'b0; chk = 1'b0;
    endtask

    // Loads A and B, issues one start edge, leaves the bench one cycle later.
    task automatic start_mult(input logic [15:0] a, input logic [15:0] b);
        bus_write(2'd0, a, 1'b1, 1);
        bus_write(2'd1, b, 1'b1, 1);
        bus_write(2'd2, 16'h0001, 1'b1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        tests = 0; fails = 0; chk = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        rst = 1'b0;
        #7 rst = 1'b1;
        idle(2);
        // Reset state, read while reset is held
        bus_read(2'd2, 1'b1, 16'h0000, "reset_status_held");
        rst = 1'b0;
        bus_read(2'd2, 1'b1, 16'h0000, "reset_status");
        bus_read(2'd0, 1'b1, 16'h0000, "reset_prod_lo");

        // Basic: 5*2, start held 4 cycles
        bus_write(2'd0, 16'd5, 1'b1, 1);
        bus_write(2'd1, 16'd2, 1'b1, 1);
        bus_write(2'd2, 16'h0001, 1'b1, 4);       // start edge N .. N+3
        bus_read(2'd2, 1'b1, 16'h0002, "basic_busy_early");  // before N+4
        idle(11);
        bus_read(2'd2, 1'b1, 16'h0002, "basic_busy_last");   // before N+16
        bus_read(2'd2, 1'b1, 16'h0001, "basic_done");        // after N+16
        bus_read(2'd0, 1'b1, 16'h000A, "basic_lo");
        bus_read(2'd1, 1'b1, 16'h0000, "basic_hi");
        bus_read(2'd3, 1'b1, 16'h0000, "addr3_read");

        // Full width
        start_mult(16'hFFFF, 16'hFFFF);
        idle(16);
        bus_read(2'd0, 1'b1, 16'h0001, "full_lo");
        bus_read(2'd1, 1'b1, 16'hFFFE, "full_hi");
        bus_read(2'd2, 1'b1, 16'h0001, "full_done");

        // Bus gating
        bus_read(2'd0, 1'b0, 16'h0000, "gated_read");
        bus_write(2'd0, 16'h1234, 1'b0, 1);
        bus_write(2'd2, 16'h0001, 1'b1, 1);
        idle(16);
        bus_read(2'd0, 1'b1, 16'h0001, "gated_write_lo");
        bus_read(2'd1, 1'b1, 16'hFFFE, "gated_write_hi");

        // Operand isolation
        start_mult(16'd3, 16'd7);
        bus_write(2'd0, 16'd100, 1'b1, 1);
        bus_read(2'd0, 1'b1, 16'h0001, "prev_prod_during_busy");
        idle(14);
        bus_read(2'd0, 1'b1, 16'd21, "iso_lo");
        bus_read(2'd1, 1'b1, 16'h0000, "iso_hi");
        bus_write(2'd2, 16'h0001, 1'b1, 1);
        bus_read(2'd2, 1'b1, 16'h0002, "restart_done_cleared");
        bus_read(2'd0, 1'b1, 16'd21, "restart_prev_prod");
        idle(14);
        bus_read(2'd0, 1'b1, 16'd700, "restart_lo");
        bus_read(2'd2, 1'b1, 16'h0001, "restart_done");

        // Abort mid-operation
        start_mult(16'd35, 16'd2);
        idle(7);
        #2 rst = 1'b1;
        #2;
        idle(1);
        bus_read(2'd2, 1'b1, 16'h0000, "abort_status_held");
        rst = 1'b0;
        bus_read(2'd2, 1'b1, 16'h0000, "abort_status");
        bus_read(2'd0, 1'b1, 16'h0000, "abort_lo");
        bus_write(2'd2, 16'h0000, 1'b1, 1);
        bus_read(2'd2, 1'b1, 16'h0000, "ctl_zero_no_start");
        idle(17);
        bus_read(2'd2, 1'b1, 16'h0000, "ctl_zero_status_late");
        bus_read(2'd0, 1'b1, 16'h0000, "ctl_zero_lo");

        idle(2);
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
